price_window_fifo: RTL and testbench

Circular price-window buffer that sits directly upstream of the incremental RSI stage. It accepts a stream of raw prices and holds the most recent WINDOW samples. For every accepted sample it emits a one-cycle `new_price_strobe` together with the new price, the oldest price still in the window, the fill count, a full flag, the evicted sample and a running window sum. The RSI stage and the SMA-type indicator stages consume these outputs without keeping their own history.

---
 rtl/price_window_fifo.sv | 129 ++++++++++++
 tb/tb_price_window_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/price_window_fifo.sv
// Sliding window of the most recent WINDOW prices feeding the RSI/SMA stages.
// For each accepted sample it reports the new, oldest and evicted prices, the fill state and a running sum.
module price_window_fifo #(
  parameter int WINDOW = 14,
  parameter int DW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              price_valid,
  input  logic [DW-1:0]     price_in,
  input  logic              flush,
  output logic              new_price_strobe,
  output logic [DW-1:0]     new_price,
  output logic [DW-1:0]     oldest_price,
  output logic [DW-1:0]     evicted_price,
  output logic              evict_valid,
  output logic              mem_full,
  output logic [4:0]        mem_count,
  output logic [DW+4:0]     window_sum
);

  localparam int PW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SW = DW + 5;
  localparam logic [PW-1:0] PTR_LAST = PW'(WINDOW - 1);
  localparam logic [4:0]    CNT_FULL = 5'(WINDOW);

  logic [DW-1:0] mem_q [WINDOW];
  logic [DW-1:0] mem_d [WINDOW];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;

  logic          strobe_q, strobe_d;
  logic [DW-1:0] new_price_q, new_price_d;
  logic [DW-1:0] oldest_q, oldest_d;
  logic [DW-1:0] evicted_q, evicted_d;
  logic          evict_valid_q, evict_valid_d;

  logic          accept;
  logic          full_before;
  logic [DW-1:0] evicted;
  logic [PW-1:0] wr_ptr_nxt;
  logic [4:0]    cnt_nxt;
  logic [DW-1:0] oldest_nxt;

  always_comb begin
    accept      = price_valid && !flush;
    full_before = (cnt_q == CNT_FULL);
    evicted     = full_before ? mem_q[wr_ptr_q] : '0;
    wr_ptr_nxt  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    cnt_nxt     = full_before ? cnt_q : cnt_q + 5'd1;

    // Slot wr_ptr_nxt is never the one being written, so reading the pre-write
    // array is safe; only the partial-fill case can need the incoming sample.
    if (cnt_nxt == CNT_FULL) begin
      oldest_nxt = mem_q[wr_ptr_nxt];
    end else if (wr_ptr_q == '0) begin
      oldest_nxt = price_in;
    end else begin
      oldest_nxt = mem_q[0];
    end

    for (int unsigned i = 0; i < WINDOW; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    strobe_d      = 1'b0;
    evict_valid_d = 1'b0;
    new_price_d   = new_price_q;
    oldest_d      = oldest_q;
    evicted_d     = evicted_q;

    if (flush) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
      sum_d    = '0;
    end else if (accept) begin
      mem_d[wr_ptr_q] = price_in;
      wr_ptr_d        = wr_ptr_nxt;
      cnt_d           = cnt_nxt;
      sum_d           = sum_q + SW'(price_in) - SW'(evicted);
      strobe_d        = 1'b1;
      evict_valid_d   = full_before;
      new_price_d     = price_in;
      oldest_d        = oldest_nxt;
      evicted_d       = evicted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < WINDOW; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      sum_q         <= '0;
      strobe_q      <= 1'b0;
      evict_valid_q <= 1'b0;
      new_price_q   <= '0;
      oldest_q      <= '0;
      evicted_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < WINDOW; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      strobe_q      <= strobe_d;
      evict_valid_q <= evict_valid_d;
      new_price_q   <= new_price_d;
      oldest_q      <= oldest_d;
      evicted_q     <= evicted_d;
    end
  end

  assign new_price_strobe = strobe_q;
  assign new_price        = new_price_q;
  assign oldest_price     = oldest_q;
  assign evicted_price    = evicted_q;
  assign evict_valid      = evict_valid_q;
  assign mem_count        = cnt_q;
  assign mem_full         = (cnt_q == CNT_FULL);
  assign window_sum       = sum_q;

endmodule

// File: tb/tb_price_window_fifo.sv
// Directed bench for price_window_fifo: a queue-based window model pushes expected
// strobe contents at drive time; a negedge monitor pops and compares them.
module tb_price_window_fifo;

  localparam int WINDOW = 14;
  localparam int DW     = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          price_valid;
  logic [DW-1:0] price_in;
  logic          flush;
  logic          new_price_strobe;
  logic [DW-1:0] new_price;
  logic [DW-1:0] oldest_price;
  logic [DW-1:0] evicted_price;
  logic          evict_valid;
  logic          mem_full;
  logic [4:0]    mem_count;
  logic [DW+4:0] window_sum;

  price_window_fifo #(.WINDOW(WINDOW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .price_valid(price_valid), .price_in(price_in), .flush(flush),
    .new_price_strobe(new_price_strobe), .new_price(new_price), .oldest_price(oldest_price),
    .evicted_price(evicted_price), .evict_valid(evict_valid), .mem_full(mem_full),
    .mem_count(mem_count), .window_sum(window_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] new_price;
    logic [31:0] oldest;
    logic [31:0] evicted;
    logic [31:0] evict_valid;
    logic [31:0] count;
    logic [31:0] full;
    logic [31:0] sum;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned window_model[$];
  int          errors = 0;
  int          checks = 0;
  int          strobe_cnt = 0;

  function automatic void check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endfunction

  // Drive one cycle of inputs; update the model and scoreboard as the DUT should.
  task automatic drive(input logic v, input logic [DW-1:0] p, input logic fl);
    exp_t        e;
    int unsigned s;
    price_valid = v;
    price_in    = p;
    flush       = fl;
    if (fl) begin
      window_model.delete();
    end else if (v) begin
      e.evicted     = 0;
      e.evict_valid = 0;
      if (window_model.size() == WINDOW) begin
        e.evicted     = window_model.pop_front();
        e.evict_valid = 1;
      end
      window_model.push_back(32'(p));
      s = 0;
      foreach (window_model[i]) s += window_model[i];
      e.new_price = 32'(p);
      e.oldest    = window_model[0];
      e.count     = window_model.size();
      e.full      = (window_model.size() == WINDOW) ? 1 : 0;
      e.sum       = s;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    price_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    price_valid = 1'b0;
    flush       = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    window_model.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_strobe"}, 32'(new_price_strobe), 0);
    check({tag, "_new"}, 32'(new_price), 0);
    check({tag, "_oldest"}, 32'(oldest_price), 0);
    check({tag, "_evicted"}, 32'(evicted_price), 0);
    check({tag, "_evv"}, 32'(evict_valid), 0);
    check({tag, "_full"}, 32'(mem_full), 0);
    check({tag, "_count"}, 32'(mem_count), 0);
    check({tag, "_sum"}, 32'(window_sum), 0);
  endtask

  always @(negedge clk) begin
    if (new_price_strobe === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_strobe got=1 expected=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_new", 32'(new_price), e.new_price);
        check("sb_oldest", 32'(oldest_price), e.oldest);
        check("sb_evicted", 32'(evicted_price), e.evicted);
        check("sb_evv", 32'(evict_valid), e.evict_valid);
        check("sb_count", 32'(mem_count), e.count);
        check("sb_full", 32'(mem_full), e.full);
        check("sb_sum", 32'(window_sum), e.sum);
      end
    end else begin
      check("idle_evv", 32'(evict_valid), 0);
    end
  end

  initial begin
    int base;
    rst         = 1'b1;
    price_valid = 1'b0;
    price_in    = '0;
    flush       = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    check_zero("reset");
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("reset_nostrobe", 32'(new_price_strobe), 0);

    // Fill 1..14
    for (int i = 1; i <= 14; i++) drive(1'b1, DW'(i), 1'b0);
    check("fill_full", 32'(mem_full), 1);
    check("fill_oldest", 32'(oldest_price), 1);
    check("fill_sum", 32'(window_sum), 105);
    check("fill_evv", 32'(evict_valid), 0);
    check("fill_count", 32'(mem_count), 14);

    // Slide
    drive(1'b1, 16'd15, 1'b0);
    check("slide_evv", 32'(evict_valid), 1);
    check("slide_evicted", 32'(evicted_price), 1);
    check("slide_oldest", 32'(oldest_price), 2);
    check("slide_sum", 32'(window_sum), 119);
    check("slide_count", 32'(mem_count), 14);

    // Wrap: 42 back-to-back samples
    do_reset(1);
    check_zero("reset2");
    @(negedge clk);
    #1;
    base = strobe_cnt;
    for (int i = 1; i <= 42; i++) drive(1'b1, DW'(i), 1'b0);
    check("wrap_oldest", 32'(oldest_price), 29);
    check("wrap_evicted", 32'(evicted_price), 28);
    check("wrap_sum", 32'(window_sum), 497);
    @(negedge clk);
    #1;
    check("wrap_strobes", 32'(strobe_cnt - base), 42);

    // Flush colliding with valid
    do_reset(1);
    for (int i = 1; i <= 14; i++) drive(1'b1, DW'(i), 1'b0);
    drive(1'b1, 16'd99, 1'b1);
    check("flush_strobe", 32'(new_price_strobe), 0);
    check("flush_count", 32'(mem_count), 0);
    check("flush_sum", 32'(window_sum), 0);
    check("flush_full", 32'(mem_full), 0);
    drive(1'b1, 16'd7, 1'b0);
    check("postflush_count", 32'(mem_count), 1);
    check("postflush_oldest", 32'(oldest_price), 7);
    check("postflush_sum", 32'(window_sum), 7);

    // Reset mid-stream, then saturate
    do_reset(1);
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i * 100), 1'b0);
    do_reset(1);
    check("midrst_count", 32'(mem_count), 0);
    drive(1'b1, 16'hFFFF, 1'b0);
    check("midrst_first_count", 32'(mem_count), 1);
    check("midrst_first_oldest", 32'(oldest_price), 32'hFFFF);
    for (int i = 2; i <= 20; i++) drive(1'b1, 16'hFFFF, 1'b0);
    check("sat_count", 32'(mem_count), 14);
    check("sat_sum", 32'(window_sum), 917490);
    check("sat_evv", 32'(evict_valid), 1);

    // Gapped writes: strobe one cycle wide, data held while idle
    drive(1'b1, 16'd500, 1'b0);
    check("gap_strobe_on", 32'(new_price_strobe), 1);
    repeat (3) drive(1'b0, 16'd0, 1'b0);
    check("gap_strobe_off", 32'(new_price_strobe), 0);
    check("gap_hold_new", 32'(new_price), 500);
    check("gap_hold_oldest", 32'(oldest_price), 32'hFFFF);
    check("gap_hold_evicted", 32'(evicted_price), 32'hFFFF);
    check("gap_hold_count", 32'(mem_count), 14);
    check("gap_hold_sum", 32'(window_sum), 917490 - 65535 + 500);
    drive(1'b1, 16'd600, 1'b0);
    check("gap2_strobe_on", 32'(new_price_strobe), 1);
    drive(1'b0, 16'd0, 1'b0);
    check("gap2_strobe_off", 32'(new_price_strobe), 0);
    check("gap2_hold_new", 32'(new_price), 600);

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
